control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit bus CPU: a T0..T4 step counter plus a
// sticky halt flag. All control lines are decoded combinationally from that state.
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halted,
    output logic [2:0] step
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] step_q;
    logic       halt_q;
    logic [2:0] last_step;

    assign step   = step_q;
    assign halted = halt_q;

    // Final microstep of each instruction; NOP and undefined opcodes stop after fetch.
    always_comb begin
        last_step = T1;
        case (opcode)
            OP_LDA, OP_STA:                         last_step = T3;
            OP_ADD, OP_SUB:                         last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                 last_step = T2;
            default:                                last_step = T1;
        endcase
    end

    // HLT freezes the counter at T2; only reset releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            if (step_q == T2 && opcode == OP_HLT) begin
                halt_q <= 1'b1;
            end else if (step_q == last_step || step_q >= T4) begin
                step_q <= T0;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        mar_in   = 1'b0;
        ram_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        if (!rst && !halt_q) begin
            case (step_q)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_jump = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = carry;
                            pc_jump = carry;
                        end
                        OP_JZ: begin
                            ir_out  = zero;
                            pc_jump = zero;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
